// File: rtl/match_event_logger.sv
// rtl/match_event_logger.sv - timestamps match pulses into a small FWFT FIFO
// with a saturating match counter and a sticky drop flag.
module match_event_logger #(
  parameter int TS_WIDTH  = 16,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 match_in,
  input  logic                 rd_en,
  output logic [TS_WIDTH-1:0]  ts_out,
  output logic                 empty,
  output logic                 full,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic                 overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_OCC = (PW+1)'(DEPTH);

  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW:0]         occ;
  logic                push;
  logic                pop;

  assign empty = (occ == '0);
  assign full  = (occ == FULL_OCC);
  assign pop   = rd_en && !empty;
  // A full FIFO still accepts a write when the same edge frees the head slot.
  assign push  = match_in && (!full || rd_en);

  // Storage is never read while empty, so ts_out is masked rather than the array reset.
  assign ts_out = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ts_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + (PW+1)'(1);
        2'b01:   occ <= occ - (PW+1)'(1);
        default: occ <= occ;
      endcase
      if (match_in && !(&match_count)) begin
        match_count <= match_count + CNT_WIDTH'(1);
      end
      if (match_in && full && !rd_en) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_match_event_logger.sv
// tb/tb_match_event_logger.sv - directed bench for match_event_logger.
module tb_match_event_logger;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        match_in = 1'b0;
  logic        rd_en    = 1'b0;
  logic [15:0] ts_out;
  logic        empty;
  logic        full;
  logic [7:0]  match_count;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;

  match_event_logger #(.TS_WIDTH(16), .DEPTH(4), .CNT_WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .match_in    (match_in),
    .rd_en       (rd_en),
    .ts_out      (ts_out),
    .empty       (empty),
    .full        (full),
    .match_count (match_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int n);
    match_in = 1'b1;
    tick(n);
    match_in = 1'b0;
  endtask

  task automatic do_reset();
    match_in = 1'b0;
    rd_en    = 1'b0;
    reset    = 1'b1;
    tick(1);
    reset    = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_ts_out"}, 32'(ts_out), 32'd0);
    chk({tag, "_count"}, 32'(match_count), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 chk_reset_state("rst_async");
    tick(1);
    chk_reset_state("rst_held");
    reset = 1'b0;

    // First post-reset edge sees ts_cnt=0, so the 6th edge carries timestamp 5.
    tick(5);
    pulse(1);
    chk("first_ts", 32'(ts_out), 32'd5);
    chk("first_empty", 32'(empty), 32'd0);
    chk("first_count", 32'(match_count), 32'd1);
    chk("first_ovf", 32'(overflow), 32'd0);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    chk("first_drained", 32'(empty), 32'd1);

    // Fill past capacity starting at timestamp 10.
    do_reset();
    tick(10);
    match_in = 1'b1;
    tick(1);
    chk("fill_head", 32'(ts_out), 32'd10);
    tick(3);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_no_ovf", 32'(overflow), 32'd0);
    tick(1);
    match_in = 1'b0;
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_count", 32'(match_count), 32'd5);
    chk("fill_still_full", 32'(full), 32'd1);
    rd_en = 1'b1;
    for (int i = 10; i <= 13; i++) begin
      chk("fill_pop", 32'(ts_out), 32'(i));
      tick(1);
    end
    rd_en = 1'b0;
    chk("fill_empty", 32'(empty), 32'd1);
    chk("fill_ts_zero", 32'(ts_out), 32'd0);
    chk("fill_ovf_sticky", 32'(overflow), 32'd1);

    // Simultaneous push and pop while full.
    do_reset();
    pulse(4);
    chk("pp_full_before", 32'(full), 32'd1);
    chk("pp_head_before", 32'(ts_out), 32'd0);
    match_in = 1'b1;
    rd_en    = 1'b1;
    tick(1);
    match_in = 1'b0;
    rd_en    = 1'b0;
    chk("pp_full", 32'(full), 32'd1);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_head", 32'(ts_out), 32'd1);
    chk("pp_count", 32'(match_count), 32'd5);
    rd_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("pp_pop", 32'(ts_out), 32'(i));
      tick(1);
    end
    rd_en = 1'b0;
    chk("pp_empty", 32'(empty), 32'd1);

    // Reads while empty (edges with ts 9..11) must leave the pointers alone.
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("er_empty", 32'(empty), 32'd1);
      chk("er_ts_zero", 32'(ts_out), 32'd0);
    end
    rd_en = 1'b0;
    pulse(1);
    chk("er_next_ts", 32'(ts_out), 32'd12);
    chk("er_next_empty", 32'(empty), 32'd0);
    pulse(3);
    chk("er_full_at_4", 32'(full), 32'd1);
    rd_en = 1'b1;
    for (int i = 12; i <= 15; i++) begin
      chk("er_pop", 32'(ts_out), 32'(i));
      tick(1);
    end
    rd_en = 1'b0;
    chk("er_drained", 32'(empty), 32'd1);

    // Counter saturation, then timestamp wrap.
    do_reset();
    match_in = 1'b1;
    tick(254);
    chk("sat_254", 32'(match_count), 32'd254);
    tick(1);
    chk("sat_255", 32'(match_count), 32'd255);
    tick(45);
    match_in = 1'b0;
    chk("sat_hold", 32'(match_count), 32'd255);
    chk("sat_ovf", 32'(overflow), 32'd1);
    chk("sat_full", 32'(full), 32'd1);
    rd_en = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      chk("sat_pop", 32'(ts_out), 32'(i));
      tick(1);
    end
    rd_en = 1'b0;
    chk("sat_empty", 32'(empty), 32'd1);
    tick(65535 - 304);
    pulse(2);
    chk("wrap_hi", 32'(ts_out), 32'd65535);
    rd_en = 1'b1;
    tick(1);
    chk("wrap_lo", 32'(ts_out), 32'd0);
    chk("wrap_lo_empty", 32'(empty), 32'd0);
    tick(1);
    rd_en = 1'b0;
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("wrap_ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset mid-operation with 3 entries and overflow set.
    do_reset();
    pulse(5);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    chk("ar_head", 32'(ts_out), 32'd1);
    chk("ar_not_full", 32'(full), 32'd0);
    chk("ar_ovf", 32'(overflow), 32'd1);
    #2 reset = 1'b1;
    #1 chk_reset_state("ar_between_edges");
    tick(1);
    reset = 1'b0;
    tick(5);
    pulse(1);
    chk("ar_post_ts", 32'(ts_out), 32'd5);
    chk("ar_post_empty", 32'(empty), 32'd0);
    chk("ar_post_count", 32'(match_count), 32'd1);
    chk("ar_post_ovf", 32'(overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
